// File: rtl/pipeline_ctrl_seq.sv
// Pipeline sequencer: merges stage stall requests, issues exception flush with
// redirect PC, and raises a sticky flag when PC stalls run past a threshold.
module pipeline_ctrl_seq #(
  parameter int                FLUSH_CYCLES  = 1,
  parameter logic [31:0]       EXC_VECTOR    = 32'h00000020,
  parameter int                CNT_W         = 8,
  parameter logic [CNT_W-1:0]  STALL_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout_o
);

  localparam logic [31:0] EXC_ERET = 32'h0000000e;
  localparam logic [CNT_W-1:0] FLUSH_LOAD =
    (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] w_flush_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [31:0]      r_pc;
  logic             r_timeout;
  logic [31:0]      w_exc_pc;
  logic             w_latch;
  logic [5:0]       w_stall;
  logic             w_flush;
  logic [31:0]      w_new_pc;

  assign w_exc_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

  always_comb begin
    w_next_state    = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_stall         = 6'b000000;
    w_flush         = 1'b0;
    w_new_pc        = 32'h0;
    w_latch         = 1'b0;
    case (r_state)
      S_RUN: begin
        if (excepttype_i != 32'h0) begin
          // Exception beats any stall request raised in the same cycle.
          w_flush  = 1'b1;
          w_new_pc = w_exc_pc;
          w_latch  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_next_state    = S_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
          end
        end else if (stallreq_from_mem) begin
          w_stall = 6'b011111;
        end else if (stallreq_from_ex) begin
          w_stall = 6'b001111;
        end else if (stallreq_from_id) begin
          w_stall = 6'b000111;
        end else if (stallreq_from_if) begin
          w_stall = 6'b000011;
        end
      end
      S_FLUSH: begin
        w_flush  = 1'b1;
        w_new_pc = r_pc;
        if (r_flush_cnt == '0) begin
          w_next_state = S_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 1'b1;
        end
      end
      default: begin
        w_next_state = S_RUN;
      end
    endcase
    if (rst) begin
      w_stall  = 6'b000000;
      w_flush  = 1'b0;
      w_new_pc = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_flush_cnt <= '0;
      r_pc        <= 32'h0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (w_latch) begin
        r_pc <= w_exc_pc;
      end
    end
  end

  // Watchdog counts consecutive PC-stall cycles; the flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_flush || !w_stall[0]) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != {CNT_W{1'b1}}) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (r_stall_cnt == STALL_TIMEOUT) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign stall           = w_stall;
  assign flush           = w_flush;
  assign new_pc          = w_new_pc;
  assign stall_timeout_o = r_timeout;

endmodule
